coproc_issuer: RTL and testbench

Host-side instruction issuer for the matrix coprocessor. Buffers 32-bit instructions written by the host into a small FIFO and issues them one at a time to the coprocessor's `instruction`/`activate_instruction` input. Waits for the coprocessor's completion strobe before issuing the next instruction. For READ instructions, captures the returned byte and hands it back to the host over a valid/ready channel.

---
 rtl/coproc_pkg.sv | 35 +++
 rtl/coproc_issuer_fifo.sv | 68 ++++++
 rtl/coproc_issuer.sv | 157 +++++++++++++++
 tb/tb_coproc_issuer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: definitions shared by the matrix coprocessor and its host-side issuer.
// Holds the opcode constants, the issuer FSM state encoding and the opcode field
// location inside a 32-bit instruction word.
package coproc_pkg;

    // Opcode field sits in the low nibble of every instruction word.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 4;

    // Opcode constants, shared with the coprocessor top.
    localparam logic [3:0] OP_READ   = 4'd1;
    localparam logic [3:0] OP_WRITE  = 4'd2;
    localparam logic [3:0] OP_SUM    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [3:0] OP_TRANSP = 4'd6;
    localparam logic [3:0] OP_SCALE  = 4'd7;
    localparam logic [3:0] OP_TRACE  = 4'd8;
    localparam logic [3:0] OP_DET2   = 4'd9;
    localparam logic [3:0] OP_DET3   = 4'd10;
    localparam logic [3:0] OP_DET4   = 4'd11;
    localparam logic [3:0] OP_DET5   = 4'd12;

    // Issuer FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    // Extract the opcode field from an instruction word.
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] word);
        return word[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage

// File: rtl/coproc_issuer_fifo.sv
// instr_fifo: DEPTH-entry, 32-bit instruction buffer with wrap-around pointers.
// A push while full is dropped; a simultaneous push and pop leave the count unchanged.
module instr_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty/full come from the reset pointers, so stale words are never read.
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/coproc_issuer.sv
// coproc_issuer: buffers host instructions and issues them one at a time to the
// matrix coprocessor, waiting for its done strobe; READ results go back to the
// host over a valid/ready channel.
// Optional watchdog: define COPROC_ISSUER_TIMEOUT_EN to abandon an instruction
// after TIMEOUT cycles in WAIT and raise the sticky timeout flag.
module coproc_issuer
    import coproc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic [31:0] instruction,
    output logic        activate_instruction,
    input  logic        done,
    input  logic [7:0]  data_out,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        timeout
);

    // Reject configurations the FIFO pointers and watchdog cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("coproc_issuer: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("coproc_issuer: TIMEOUT must be >= 2");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        fifo_pop, fifo_empty;
    logic [31:0] fifo_data;
    logic        wd_expired;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (fifo_empty)
    );

`ifdef COPROC_ISSUER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Expiry fires in the TIMEOUT-th WAIT cycle when done is still absent.
    assign wd_expired = (state_q == ST_WAIT) && !done && (wd_cnt_q == WD_LAST);
    assign timeout    = timeout_q;

    // Watchdog: cleared in ISSUE (entry to WAIT), counts each WAIT cycle without done.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_q == ST_ISSUE) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_WAIT && !done) begin
            if (wd_expired) timeout_d = 1'b1;
            else            wd_cnt_d  = wd_cnt_q + WD_ONE;
        end
    end

    // Watchdog registers; the flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Issue FSM: pop in IDLE, strobe in ISSUE, wait for done, hold READ results.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_data;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // done in this cycle belongs to no instruction of ours and is ignored.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    if (get_opcode(instr_q) == OP_READ) begin
                        rd_data_d  = data_out;
                        rd_valid_d = 1'b1;
                        state_d    = ST_RESULT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESULT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, held instruction and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign instruction          = instr_q;
    assign activate_instruction = (state_q == ST_ISSUE);
    assign rd_valid             = rd_valid_q;
    assign rd_data              = rd_data_q;
    assign busy                 = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_coproc_issuer.sv
// tb_coproc_issuer: directed-vector bench for coproc_issuer (DEPTH=8, TIMEOUT=16).
// Inputs change 1 ns after the rising edge; outputs are compared at the same point.
module tb_coproc_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic [31:0] instruction;
    logic        activate_instruction;
    logic        done;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic        busy;
    logic        timeout;

    int n_vec  = 0;
    int n_miss = 0;

    int strobe_cnt = 0;
    int strobe_run = 0;
    int strobe_max = 0;
    int rdv_cnt    = 0;

    coproc_issuer #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .full                 (full),
        .instruction          (instruction),
        .activate_instruction (activate_instruction),
        .done                 (done),
        .data_out             (data_out),
        .rd_valid             (rd_valid),
        .rd_data              (rd_data),
        .rd_ready             (rd_ready),
        .busy                 (busy),
        .timeout              (timeout)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count strobes, the longest strobe run and cycles with rd_valid high.
    always @(negedge clk) begin
        if (activate_instruction === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_run = strobe_run + 1;
            if (strobe_run > strobe_max) strobe_max = strobe_run;
        end else begin
            strobe_run = 0;
        end
        if (rd_valid === 1'b1) rdv_cnt = rdv_cnt + 1;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100 us");
        $fatal(1, "bench stalled");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulse done for one cycle with the given read data.
    task automatic finish_op(input logic [7:0] d);
        done     = 1'b1;
        data_out = d;
        tick();
        done     = 1'b0;
        data_out = 8'h00;
    endtask

    // Wait (bounded) for the issue strobe, then compare the issued word.
    task automatic wait_strobe(input string tag, input logic [31:0] w);
        int n = 0;
        while (activate_instruction !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_strobe"}, {31'b0, activate_instruction}, 32'h1);
        check({tag, "_instr"}, instruction, w);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, instruction, 32'h0);
        check({tag, "_act"},   {31'b0, activate_instruction}, 32'h0);
        check({tag, "_rdv"},   {31'b0, rd_valid}, 32'h0);
        check({tag, "_rdd"},   {24'b0, rd_data}, 32'h0);
        check({tag, "_full"},  {31'b0, full}, 32'h0);
        check({tag, "_busy"},  {31'b0, busy}, 32'h0);
        check({tag, "_tmo"},   {31'b0, timeout}, 32'h0);
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return 32'hC000_0002 | (32'(i) << 4);
    endfunction

    function automatic logic [31:0] chain_word(input int i);
        return 32'h5A00_0003 | (32'(i) << 8);
    endfunction

    initial begin
        int s;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        done     = 1'b0;
        data_out = 8'h00;
        rd_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single WRITE: latency N+2, one strobe, done 3 cycles after it.
        s = strobe_cnt;
        push(32'h0000_0052);
        check("t1_lat_n1", {31'b0, activate_instruction}, 32'h0);
        tick();
        check("t1_lat_n2", {31'b0, activate_instruction}, 32'h1);
        check("t1_instr", instruction, 32'h0000_0052);
        repeat (3) tick();
        check("t1_wait_busy", {31'b0, busy}, 32'h1);
        finish_op(8'h00);
        check("t1_busy_fall", {31'b0, busy}, 32'h0);
        check("t1_instr_hold", instruction, 32'h0000_0052);
        check("t1_one_strobe", 32'(strobe_cnt - s), 32'h1);
        check("t1_no_rdv", 32'(rdv_cnt), 32'h0);

        // READ return, held until rd_ready; the queued WRITE waits for the handshake.
        s = strobe_cnt;
        push(32'h0000_0101);
        push(32'h0000_0052);
        check("t2_rd_strobe", {31'b0, activate_instruction}, 32'h1);
        check("t2_rd_instr", instruction, 32'h0000_0101);
        tick();
        finish_op(8'hA5);
        check("t2_rdv", {31'b0, rd_valid}, 32'h1);
        check("t2_rdd", {24'b0, rd_data}, 32'h0000_00A5);
        repeat (5) tick();
        check("t2_rdv_hold", {31'b0, rd_valid}, 32'h1);
        check("t2_rdd_hold", {24'b0, rd_data}, 32'h0000_00A5);
        check("t2_no_issue", 32'(strobe_cnt - s), 32'h1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t2_rdv_clr", {31'b0, rd_valid}, 32'h0);
        check("t2_idle_act", {31'b0, activate_instruction}, 32'h0);
        tick();
        check("t2_next_strobe", {31'b0, activate_instruction}, 32'h1);
        check("t2_next_instr", instruction, 32'h0000_0052);
        // done during ISSUE must be ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) tick();
        check("t2_issue_done_ign", {31'b0, busy}, 32'h1);
        finish_op(8'h00);
        check("t2_busy_fall", {31'b0, busy}, 32'h0);
        check("t2_strobes", 32'(strobe_cnt - s), 32'h2);

        // Fill/overflow behind a blocked instruction; the 9th push is dropped.
        s = strobe_cnt;
        push(32'h0000_0003);
        wait_strobe("t3_blk", 32'h0000_0003);
        tick();
        for (int i = 1; i <= 9; i++) begin
            push(fill_word(i));
            if (i == 7) check("t3_not_full7", {31'b0, full}, 32'h0);
            if (i == 8) check("t3_full8", {31'b0, full}, 32'h1);
            if (i == 9) check("t3_full9", {31'b0, full}, 32'h1);
        end
        finish_op(8'h00);
        for (int i = 1; i <= 8; i++) begin
            wait_strobe($sformatf("t3_drain%0d", i), fill_word(i));
            tick();
            finish_op(8'h00);
        end
        repeat (3) tick();
        check("t3_empty", {31'b0, busy}, 32'h0);
        check("t3_strobes", 32'(strobe_cnt - s), 32'h9);

        // Push in the same cycle IDLE pops the last entry, across pointer wrap.
        s = strobe_cnt;
        push(chain_word(0));
        push(chain_word(1));
        check("t4_w0", instruction, chain_word(0));
        tick();
        for (int i = 1; i <= 9; i++) begin
            done = 1'b1;
            tick();
            done    = 1'b0;
            wr_en   = 1'b1;
            wr_data = chain_word(i + 1);
            tick();
            wr_en = 1'b0;
            check($sformatf("t4_w%0d", i), instruction, chain_word(i));
            check($sformatf("t4_full%0d", i), {31'b0, full}, 32'h0);
            tick();
        end
        finish_op(8'h00);
        wait_strobe("t4_last", chain_word(10));
        tick();
        finish_op(8'h00);
        check("t4_empty", {31'b0, busy}, 32'h0);
        check("t4_strobes", 32'(strobe_cnt - s), 32'd11);

        // Reset mid-WAIT with 3 entries queued.
        push(32'h0000_0004);
        wait_strobe("t5_blk", 32'h0000_0004);
        tick();
        push(32'h0000_0012);
        push(32'h0000_0022);
        push(32'h0000_0032);
        check("t5_busy_pre", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #2;
        check_all_zero("t5_async");
        tick();
        check_all_zero("t5_held");
        rst = 1'b0;
        done     = 1'b1;
        data_out = 8'hFF;
        tick();
        done     = 1'b0;
        data_out = 8'h00;
        s = strobe_cnt;
        repeat (6) tick();
        check("t5_no_issue", 32'(strobe_cnt - s), 32'h0);
        check("t5_idle", {31'b0, busy}, 32'h0);
        check("t5_no_rdv", {31'b0, rd_valid}, 32'h0);
        push(32'h0000_0070);
        wait_strobe("t5_op0", 32'h0000_0070);
        tick();
        finish_op(8'h00);
        check("t5_empty", {31'b0, busy}, 32'h0);

        // Watchdog behaviour (compiled in) or indefinite WAIT (compiled out).
        s = strobe_cnt;
        push(32'h0000_0082);
        push(32'h0000_0092);
        check("t6_first", instruction, 32'h0000_0082);
        tick();
`ifdef COPROC_ISSUER_TIMEOUT_EN
        repeat (15) tick();
        check("t6_tmo_pre", {31'b0, timeout}, 32'h0);
        tick();
        check("t6_tmo_set", {31'b0, timeout}, 32'h1);
        tick();
        check("t6_next_strobe", {31'b0, activate_instruction}, 32'h1);
        check("t6_next_instr", instruction, 32'h0000_0092);
        tick();
        finish_op(8'h00);
        check("t6_busy_fall", {31'b0, busy}, 32'h0);
        check("t6_tmo_sticky", {31'b0, timeout}, 32'h1);
`else
        repeat (40) tick();
        check("t6_tmo_off", {31'b0, timeout}, 32'h0);
        check("t6_still_wait", {31'b0, busy}, 32'h1);
        check("t6_no_next", 32'(strobe_cnt - s), 32'h1);
        finish_op(8'h00);
        wait_strobe("t6_next", 32'h0000_0092);
        tick();
        finish_op(8'h00);
        check("t6_busy_fall", {31'b0, busy}, 32'h0);
`endif

        check("strobe_width", 32'(strobe_max), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
